// File: rtl/fifo_drain_arb_pkg.sv
// Shared types and default sizing for the FIFO drain arbiter.
// Imported by the interface, the picker and the top.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   localparam int N_REQ_DEF     = 4;
   localparam int DATA_W_DEF    = 32;
   localparam int BURST_MAX_DEF = 4;
   localparam int SRC_W_DEF     = 2;

   // Index after i in a ring of n slots.
   function automatic int ring_next(int i, int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/fifo_drain_arb_if.sv
// Downstream valid/ready stream of the drain arbiter.
// Each word carries the index of the FIFO it came from.
interface fifo_drain_arb_if
   import fifo_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int SRC_W  = SRC_W_DEF
);

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [SRC_W-1:0]  out_src;

   modport master (
      output out_valid,
      output out_data,
      output out_src,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_src,
      output out_ready
   );

endinterface

// File: rtl/fifo_drain_arb_rr_pick.sv
// Rotate-priority selector: first set request at or after ptr.
// Purely combinational; ptr is assumed to be below N_REQ.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int SRC_W = SRC_W_DEF
) (
   input  logic [N_REQ-1:0] req,
   input  logic [SRC_W-1:0] ptr,
   output logic [SRC_W-1:0] idx,
   output logic             any
);

   function automatic logic [SRC_W-1:0] slot(
      logic [SRC_W-1:0] p,
      int               k
   );
      return SRC_W'((int'(p) + k) % N_REQ);
   endfunction

   // Walk offsets high to low so the nearest request wins.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[slot(ptr, k)]) begin
            idx = slot(ptr, k);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_drain_arb.sv
// Round-robin read scheduler draining N async FIFOs into one
// tagged valid/ready stream through a 2-entry output buffer.
module fifo_drain_arb
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = N_REQ_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BURST_MAX = BURST_MAX_DEF,
   parameter int SRC_W     = SRC_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          fifo_empty,
   output logic [N_REQ-1:0]          fifo_rd_en,
   input  logic [N_REQ*DATA_W-1:0]   fifo_rd_data,
   fifo_drain_arb_if.master          ob,
   output logic                      busy
);

   localparam logic [3:0] BMAX = 4'(BURST_MAX);

   state_t             state;
   logic [SRC_W-1:0]   grant;
   logic [SRC_W-1:0]   rr_ptr;
   logic [3:0]         burst_cnt;

   logic               inflight;
   logic [SRC_W-1:0]   inflight_src;

   logic [DATA_W-1:0]  buf_data [2];
   logic [SRC_W-1:0]   buf_src  [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         buf_cnt;

   logic [N_REQ-1:0]   req;
   logic [SRC_W-1:0]   pick_idx;
   logic               pick_any;
   logic [SRC_W-1:0]   nxt_ptr;
   logic               pop;
   logic               room;
   logic               can_issue;
   logic [DATA_W-1:0]  cap_word;

   assign req = ~fifo_empty;

   rr_pick #(
      .N_REQ (N_REQ),
      .SRC_W (SRC_W)
   ) u_pick (
      .req (req),
      .ptr (rr_ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign nxt_ptr = SRC_W'(ring_next(int'(grant), N_REQ));

   assign pop = ob.out_valid && ob.out_ready;

   // Occupancy after this cycle's pop must leave a slot for the new read.
   assign room = ({1'b0, buf_cnt}
                + {2'b00, inflight}
                - {2'b00, pop}) < 3'd2;

   assign can_issue = (state == BURST)
                   && !fifo_empty[grant]
                   && room
                   && (burst_cnt < BMAX);

   always_comb begin
      fifo_rd_en = '0;
      if (can_issue) fifo_rd_en[grant] = 1'b1;
   end

   assign cap_word =
      fifo_rd_data[int'(inflight_src) * DATA_W +: DATA_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_any) begin
                  grant     <= pick_idx;
                  burst_cnt <= '0;
                  state     <= BURST;
               end
            end
            BURST: begin
               if (can_issue && burst_cnt < BMAX)
                  burst_cnt <= burst_cnt + 4'd1;
               // Stalled cycles neither read nor spend budget.
               if (fifo_empty[grant]
                   || (can_issue && burst_cnt == BMAX - 4'd1)) begin
                  rr_ptr <= nxt_ptr;
                  state  <= IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight     <= 1'b0;
         inflight_src <= '0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         buf_cnt      <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            buf_data[i] <= '0;
            buf_src[i]  <= '0;
         end
      end else begin
         inflight <= can_issue;
         if (can_issue) inflight_src <= grant;
         if (inflight) begin
            buf_data[wr_ptr] <= cap_word;
            buf_src[wr_ptr]  <= inflight_src;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         unique case (1'b1)
            inflight && !pop: buf_cnt <= buf_cnt + 2'd1;
            pop && !inflight: buf_cnt <= buf_cnt - 2'd1;
            default:          buf_cnt <= buf_cnt;
         endcase
      end
   end

   assign ob.out_valid = (buf_cnt != 2'd0);
   assign ob.out_data  = buf_data[rd_ptr];
   assign ob.out_src   = buf_src[rd_ptr];

   assign busy = (state == BURST) || inflight || (buf_cnt != 2'd0);

endmodule

// File: tb/tb_fifo_drain_arb.sv
// Directed bench for fifo_drain_arb with four modelled FIFOs
// whose rd_data is registered one cycle after rd_en.
module tb_fifo_drain_arb;

   logic         clk;
   logic         rst_n;
   logic [3:0]   fifo_empty;
   logic [3:0]   fifo_rd_en;
   logic [127:0] fifo_rd_data;
   logic         busy;

   fifo_drain_arb_if #(.DATA_W(32), .SRC_W(2)) ob ();

   fifo_drain_arb #(
      .N_REQ     (4),
      .DATA_W    (32),
      .BURST_MAX (4),
      .SRC_W     (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .ob           (ob.master),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [4][32];
   int          hd [4];
   int          tl [4];
   logic [31:0] rdq [4];

   int          rt [64];
   int          ri [64];
   int          rn;
   logic [31:0] od [64];
   int          os [64];
   int          ot [64];
   int          on;
   int          cyc;
   int          outstanding;
   int          viol;

   int          vectors;
   int          miscompares;

   task automatic upd();
      for (int i = 0; i < 4; i++) begin
         fifo_empty[i] = (hd[i] == tl[i]);
         fifo_rd_data[i*32 +: 32] = rdq[i];
      end
   endtask

   task automatic push_w(input int f, input logic [31:0] d);
      mem[f][tl[f]] = d;
      tl[f] = tl[f] + 1;
      upd();
   endtask

   task automatic flush_fifos();
      for (int i = 0; i < 4; i++) begin
         hd[i] = 0;
         tl[i] = 0;
      end
      upd();
   endtask

   task automatic clear_logs();
      rn  = 0;
      on  = 0;
      cyc = 0;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge, then advance the FIFO model.
   task automatic tick();
      logic [3:0] rd_s;
      int         p;
      int         idx;
      @(negedge clk);
      rd_s = fifo_rd_en;
      p    = (ob.out_valid && ob.out_ready) ? 1 : 0;
      idx  = -1;
      for (int i = 0; i < 4; i++)
         if (rd_s[i]) idx = i;
      if ((rd_s & fifo_empty) != 4'd0) viol++;
      if (!$onehot0(rd_s)) viol++;
      if (rd_s != 4'd0 && outstanding - p >= 2) viol++;
      if (rd_s != 4'd0 && rn < 64) begin
         rt[rn] = cyc;
         ri[rn] = idx;
         rn++;
      end
      if (p == 1 && on < 64) begin
         od[on] = ob.out_data;
         os[on] = int'(ob.out_src);
         ot[on] = cyc;
         on++;
      end
      outstanding = outstanding + ((rd_s != 4'd0) ? 1 : 0) - p;
      if (outstanding > 2) viol++;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (rd_s[i] && hd[i] != tl[i]) begin
            rdq[i] = mem[i][hd[i]];
            hd[i]  = hd[i] + 1;
         end
      end
      upd();
      cyc++;
   endtask

   int exp_rt [12];
   int exp_ri [12];
   logic [31:0] exp_od [12];

   initial begin
      vectors     = 0;
      miscompares = 0;
      viol        = 0;
      outstanding = 0;
      ob.out_ready = 1'b1;
      fifo_empty   = '1;
      fifo_rd_data = '0;
      for (int i = 0; i < 4; i++) rdq[i] = '0;
      flush_fifos();
      clear_logs();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      repeat (2) tick();

      chk("rst_rd_en", 32'(fifo_rd_en), 0);
      chk("rst_valid", 32'(ob.out_valid), 0);
      chk("rst_data", ob.out_data, 0);
      chk("rst_src", 32'(ob.out_src), 0);
      chk("rst_busy", 32'(busy), 0);

      // Single source, first read on second edge after release
      push_w(1, 32'hA0);
      push_w(1, 32'hA1);
      push_w(1, 32'hA2);
      clear_logs();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("ss_reads", rn, 3);
      chk("ss_first_rd", rt[0], 1);
      chk("ss_outs", on, 3);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("ss_idx%0d", k), ri[k], 1);
         chk($sformatf("ss_data%0d", k), od[k], 32'hA0 + k);
         chk($sformatf("ss_src%0d", k), os[k], 1);
         chk($sformatf("ss_t%0d", k), ot[k], 3 + k);
      end

      // Move pointer to 3, then wrap from FIFO 3 to FIFO 0
      clear_logs();
      push_w(2, 32'hC0);
      repeat (6) tick();
      chk("wr_pre_reads", rn, 1);
      chk("wr_pre_idx", ri[0], 2);
      clear_logs();
      push_w(3, 32'hD0);
      push_w(3, 32'hD1);
      push_w(0, 32'hE0);
      push_w(0, 32'hE1);
      repeat (12) tick();
      chk("wr_reads", rn, 4);
      chk("wr_idx0", ri[0], 3);
      chk("wr_idx1", ri[1], 3);
      chk("wr_idx2", ri[2], 0);
      chk("wr_idx3", ri[3], 0);
      chk("wr_data0", od[0], 32'hD0);
      chk("wr_data2", od[2], 32'hE0);
      chk("wr_src3", os[3], 0);

      // Reset with two words buffered
      clear_logs();
      ob.out_ready = 1'b0;
      for (int k = 0; k < 6; k++) push_w(3, 32'h50 + k);
      repeat (5) tick();
      chk("rm_valid_pre", 32'(ob.out_valid), 1);
      chk("rm_data_pre", ob.out_data, 32'h50);
      ob.out_ready = 1'b1;
      #1;
      chk("rm_rd_en_pre", 32'(fifo_rd_en), 32'h8);
      rst_n = 1'b0;
      #1;
      chk("rm_valid", 32'(ob.out_valid), 0);
      chk("rm_rd_en", 32'(fifo_rd_en), 0);
      chk("rm_busy", 32'(busy), 0);
      flush_fifos();
      outstanding = 0;
      tick();
      push_w(1, 32'h61);
      push_w(3, 32'h63);
      clear_logs();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("rm_reads", rn, 2);
      chk("rm_first_idx", ri[0], 1);
      chk("rm_first_rd", rt[0], 1);
      chk("rm_next_idx", ri[1], 3);
      chk("rm_out0", od[0], 32'h61);
      chk("rm_src0", os[0], 1);

      // Burst rotation 4/4/2/2 with one idle cycle between bursts
      clear_logs();
      for (int k = 0; k < 6; k++) begin
         push_w(0, 32'h100 + k);
         push_w(2, 32'h200 + k);
      end
      exp_rt = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12, 15, 16};
      exp_ri = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 2, 2};
      exp_od = '{32'h100, 32'h101, 32'h102, 32'h103,
                 32'h200, 32'h201, 32'h202, 32'h203,
                 32'h104, 32'h105, 32'h204, 32'h205};
      repeat (24) tick();
      chk("rot_reads", rn, 12);
      chk("rot_outs", on, 12);
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("rot_t%0d", k), rt[k], exp_rt[k]);
         chk($sformatf("rot_idx%0d", k), ri[k], exp_ri[k]);
         chk($sformatf("rot_data%0d", k), od[k], exp_od[k]);
         chk($sformatf("rot_src%0d", k), os[k], exp_ri[k]);
      end

      // Backpressure: 10 stalled cycles inside a burst
      clear_logs();
      for (int k = 0; k < 6; k++) push_w(1, 32'h300 + k);
      repeat (2) tick();
      ob.out_ready = 1'b0;
      repeat (5) tick();
      chk("bp_valid", 32'(ob.out_valid), 1);
      chk("bp_head", ob.out_data, 32'h300);
      chk("bp_src", 32'(ob.out_src), 1);
      chk("bp_rd_en", 32'(fifo_rd_en), 0);
      repeat (5) tick();
      ob.out_ready = 1'b1;
      repeat (14) tick();
      exp_rt[0:5] = '{1, 2, 12, 13, 15, 16};
      chk("bp_reads", rn, 6);
      chk("bp_outs", on, 6);
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("bp_t%0d", k), rt[k], exp_rt[k]);
         chk($sformatf("bp_data%0d", k), od[k], 32'h300 + k);
      end
      chk("bp_viol", viol, 0);

      // Granted FIFO runs dry after 2 of 4 reads
      clear_logs();
      push_w(2, 32'h400);
      push_w(2, 32'h401);
      push_w(1, 32'h410);
      push_w(3, 32'h430);
      repeat (14) tick();
      chk("em_reads", rn, 4);
      chk("em_idx0", ri[0], 2);
      chk("em_idx1", ri[1], 2);
      chk("em_idx2", ri[2], 3);
      chk("em_idx3", ri[3], 1);
      chk("em_t2", rt[2], 5);
      chk("em_t3", rt[3], 8);
      chk("em_data2", od[2], 32'h430);
      chk("em_data3", od[3], 32'h410);
      chk("em_busy", 32'(busy), 0);
      chk("all_viol", viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
